// File: rtl/wam_pkg.sv
// Shared types and widths for the whack-a-mole round controller.
//
// Contents:
//   game_state_t : round sequencing states (IDLE, READY, PLAYING, PAUSED, OVER)
//   TIME_W       : width of the seconds-remaining counter (up to 63 s)
//   READY_W      : width of the pre-round countdown counter (up to 3 s)
package wam_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READY   = 3'd1,
        PLAYING = 3'd2,
        PAUSED  = 3'd3,
        OVER    = 3'd4
    } game_state_t;

    localparam int TIME_W  = 6;
    localparam int READY_W = 2;

endpackage

// File: rtl/wam_sec_prescaler.sv
// Game-second prescaler: divides the system clock down to one terminal
// count per game second.
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-low reset
//   enable in  advance the counter this cycle
//   clear  in  force the counter to zero (wins over enable)
//   term   out high while the counter sits at TICK_DIV-1
module wam_sec_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic term
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign term = (cnt == LAST);

    // Counter wraps to zero on its own terminal count so every game second
    // lasts exactly TICK_DIV enabled cycles; when disabled it simply holds,
    // which is what lets a paused round resume mid-second.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= term ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wam_round_ctrl.sv
// Whack-a-mole round controller: sequences IDLE -> READY countdown ->
// PLAYING -> OVER, owns the game-second prescaler and the seconds-remaining
// counter, and drives the round status flags for the rest of the game.
//
// Build option: define WAM_PAUSE_EN to add the pause_btn port and the
// PLAYING <-> PAUSED toggle. Without it PAUSED is never entered.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   start_btn    in   1-cycle start pulse (debounced, synchronised)
//   pause_btn    in   1-cycle pause toggle pulse (WAM_PAUSE_EN only)
//   state        out  current game_state_t
//   ready_count  out  READY seconds remaining
//   time_left    out  PLAYING seconds remaining
//   sec_tick     out  1-cycle pulse on each PLAYING second boundary
//   round_active out  high only in PLAYING
//   game_over    out  high only in OVER
module wam_round_ctrl
    import wam_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int GAME_SECS  = 60,
    parameter int READY_SECS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
`ifdef WAM_PAUSE_EN
    input  logic               pause_btn,
`endif
    output game_state_t        state,
    output logic [READY_W-1:0] ready_count,
    output logic [TIME_W-1:0]  time_left,
    output logic               sec_tick,
    output logic               round_active,
    output logic               game_over
);

    localparam logic [TIME_W-1:0]  GAME_INIT  = TIME_W'(GAME_SECS);
    localparam logic [READY_W-1:0] READY_INIT = READY_W'(READY_SECS);

    logic pause_req;

`ifdef WAM_PAUSE_EN
    assign pause_req = pause_btn;
`else
    assign pause_req = 1'b0;
`endif

    game_state_t        state_nxt;
    logic [READY_W-1:0] ready_nxt;
    logic [TIME_W-1:0]  time_nxt;
    logic               tick_nxt;
    logic               term;
    logic               presc_en;
    logic               presc_clr;
    logic               pause_toggle;

    // The prescaler only runs while a countdown is in progress. Any state
    // change restarts the second, except the PLAYING <-> PAUSED toggle,
    // which must keep the partial second so resuming loses no time.
    assign presc_en     = (state == READY) || (state == PLAYING);
    assign pause_toggle = ((state == PLAYING) && (state_nxt == PAUSED)) ||
                          ((state == PAUSED)  && (state_nxt == PLAYING));
    assign presc_clr    = (state_nxt != state) && !pause_toggle;

    wam_sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (presc_en),
        .clear  (presc_clr),
        .term   (term)
    );

    // Next-state and next-counter logic. A term in PLAYING always applies
    // its decrement and tick first; only then is a simultaneous pause
    // honoured, and the final second's term sends the round to OVER
    // regardless of any pause request.
    always_comb begin
        state_nxt = state;
        ready_nxt = ready_count;
        time_nxt  = time_left;
        tick_nxt  = 1'b0;

        case (state)
            IDLE, OVER: begin
                if (start_btn) begin
                    time_nxt = GAME_INIT;
                    if (READY_SECS == 0) begin
                        state_nxt = PLAYING;
                        ready_nxt = '0;
                    end else begin
                        state_nxt = READY;
                        ready_nxt = READY_INIT;
                    end
                end
            end
            READY: begin
                if (term) begin
                    ready_nxt = ready_count - READY_W'(1);
                    if (ready_count == READY_W'(1)) begin
                        state_nxt = PLAYING;
                        time_nxt  = GAME_INIT;
                    end
                end
            end
            PLAYING: begin
                if (term) begin
                    tick_nxt = 1'b1;
                    time_nxt = time_left - TIME_W'(1);
                    if (time_left == TIME_W'(1)) begin
                        state_nxt = OVER;
                    end else if (pause_req) begin
                        state_nxt = PAUSED;
                    end
                end else if (pause_req) begin
                    state_nxt = PAUSED;
                end
            end
            PAUSED: begin
                if (pause_req) begin
                    state_nxt = PLAYING;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // All outputs are registered; the status flags are decoded from the
    // next state so they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ready_count  <= '0;
            time_left    <= GAME_INIT;
            sec_tick     <= 1'b0;
            round_active <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_nxt;
            ready_count  <= ready_nxt;
            time_left    <= time_nxt;
            sec_tick     <= tick_nxt;
            round_active <= (state_nxt == PLAYING);
            game_over    <= (state_nxt == OVER);
        end
    end

endmodule

// File: tb/tb_wam_round_ctrl.sv
// Self-checking bench for wam_round_ctrl with TICK_DIV=4, GAME_SECS=5,
// READY_SECS=2. The reference model tracks a round as "enabled cycles
// elapsed since the round started" and derives every output from that
// count arithmetically.
module tb_wam_round_ctrl;
    import wam_pkg::*;

    localparam int TD    = 4;
    localparam int GS    = 5;
    localparam int RS    = 2;
    localparam int RT    = TD * RS;
    localparam int TOTAL = TD * (RS + GS);

    logic clk;
    logic reset;
    logic start_btn;
`ifdef WAM_PAUSE_EN
    logic pause_btn;
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    game_state_t        state;
    logic [READY_W-1:0] ready_count;
    logic [TIME_W-1:0]  time_left;
    logic               sec_tick;
    logic               round_active;
    logic               game_over;
    logic [13:0]        dut_vec;

    int checks = 0;
    int errors = 0;

    assign dut_vec = {state, ready_count, time_left, sec_tick, round_active, game_over};

    wam_round_ctrl #(
        .TICK_DIV   (TD),
        .GAME_SECS  (GS),
        .READY_SECS (RS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_btn    (start_btn),
`ifdef WAM_PAUSE_EN
        .pause_btn    (pause_btn),
`endif
        .state        (state),
        .ready_count  (ready_count),
        .time_left    (time_left),
        .sec_tick     (sec_tick),
        .round_active (round_active),
        .game_over    (game_over)
    );

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model state.
    bit m_run;
    bit m_paused;
    bit m_tick;
    int m_e;

    task automatic model_reset();
        m_run    = 1'b0;
        m_paused = 1'b0;
        m_tick   = 1'b0;
        m_e      = 0;
    endtask

    // Advance the model by one clock edge with the inputs that edge samples.
    task automatic model_step(input bit s, input bit p);
        bit was_playing;
        m_tick = 1'b0;
        if (!m_run) begin
            if (s) begin
                m_run = 1'b1;
                m_e   = 0;
            end
        end else if (m_paused) begin
            if (p) m_paused = 1'b0;
        end else if (m_e >= TOTAL) begin
            if (s) m_e = 0;
        end else begin
            was_playing = (m_e >= RT);
            m_e++;
            m_tick = (m_e > RT) && (((m_e - RT) % TD) == 0);
            if (p && was_playing && (m_e < TOTAL)) m_paused = 1'b1;
        end
    endtask

    function automatic logic [13:0] exp_vec();
        game_state_t       st;
        logic [1:0]        rc;
        logic [5:0]        tl;
        if (!m_run) begin
            st = IDLE;
            rc = 2'd0;
            tl = 6'(GS);
        end else begin
            rc = (m_e < RT) ? 2'(RS - m_e / TD) : 2'd0;
            if (m_e < RT)         tl = 6'(GS);
            else if (m_e < TOTAL) tl = 6'(GS - (m_e - RT) / TD);
            else                  tl = 6'd0;
            if (m_paused)         st = PAUSED;
            else if (m_e < RT)    st = READY;
            else if (m_e < TOTAL) st = PLAYING;
            else                  st = OVER;
        end
        return {st, rc, tl, m_tick, (st == PLAYING), (st == OVER)};
    endfunction

    task automatic show_fail(input string name, input logic [13:0] got, input logic [13:0] want);
        $display("[TB] FAIL %s t=%0t got st=%0d rc=%0d tl=%0d tick=%0b act=%0b over=%0b, expected st=%0d rc=%0d tl=%0d tick=%0b act=%0b over=%0b",
                 name, $time, got[13:11], got[10:9], got[8:3], got[2], got[1], got[0],
                 want[13:11], want[10:9], want[8:3], want[2], want[1], want[0]);
    endtask

    // Present inputs for one edge, let the DUT and model take it, then
    // settle 1 unit past the edge and drop the pulses.
    task automatic drive_edge(input bit s, input bit p);
        start_btn = s;
`ifdef WAM_PAUSE_EN
        pause_btn = p;
`endif
        @(posedge clk);
        model_step(s, p & PAUSE_ON);
        #1;
        start_btn = 1'b0;
`ifdef WAM_PAUSE_EN
        pause_btn = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [13:0] want;
        // reset falls at t=2, before any rising edge
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        want = exp_vec();
        if (dut_vec !== want) begin errors++; show_fail("reset_async", dut_vec, want); end
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== want) begin errors++; show_fail("reset_held", dut_vec, want); end
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 1'b0);
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("reset_idle", dut_vec, want); end
        end
    endtask

    task automatic test_round();
        logic [13:0] want;
        int lat;
        int gap;
        gap = $urandom_range(1, 5);
        for (int i = 0; i < gap; i++) begin
            drive_edge(1'b0, 1'b0);
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("round_idle", dut_vec, want); end
        end
        drive_edge(1'b1, 1'b0);
        checks++;
        want = exp_vec();
        if (dut_vec !== want) begin errors++; show_fail("round_start", dut_vec, want); end
        lat = 0;
        while (!game_over && lat < 200) begin
            drive_edge(1'b0, 1'b0);
            lat++;
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("round_run", dut_vec, want); end
        end
        checks++;
        if (lat !== TOTAL) begin
            errors++;
            $display("[TB] FAIL round_latency got %0d cycles, expected %0d", lat, TOTAL);
        end
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 1'b0);
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("round_over_hold", dut_vec, want); end
        end
    endtask

    task automatic test_start_ignored();
        logic [13:0] want;
        int lat;
        drive_edge(1'b1, 1'b0);
        checks++;
        want = exp_vec();
        if (dut_vec !== want) begin errors++; show_fail("ign_start", dut_vec, want); end
        lat = 0;
        while (!game_over && lat < 200) begin
            drive_edge((m_e < TOTAL) && ($urandom_range(0, 2) == 0), 1'b0);
            lat++;
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("ign_run", dut_vec, want); end
        end
        checks++;
        if (lat !== TOTAL) begin
            errors++;
            $display("[TB] FAIL ign_latency got %0d cycles, expected %0d", lat, TOTAL);
        end
    endtask

    task automatic test_mid_reset();
        logic [13:0] want;
        int lat;
        int target;
        drive_edge(1'b1, 1'b0);
        target = RT + 2 * TD + $urandom_range(0, TD - 1);
        for (int i = 0; i < target; i++) begin
            drive_edge(1'b0, 1'b0);
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("mid_run", dut_vec, want); end
        end
        checks++;
        if (time_left !== 6'd3) begin
            errors++;
            $display("[TB] FAIL mid_time_left got %0d, expected 3", time_left);
        end
        // assert reset mid-cycle and look before any further edge
        #3 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        want = exp_vec();
        if (dut_vec !== want) begin errors++; show_fail("mid_reset_async", dut_vec, want); end
        #2 reset = 1'b1;
        drive_edge(1'b1, 1'b0);
        checks++;
        want = exp_vec();
        if (dut_vec !== want) begin errors++; show_fail("mid_restart", dut_vec, want); end
        lat = 0;
        while (!game_over && lat < 200) begin
            drive_edge(1'b0, 1'b0);
            lat++;
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("mid_replay", dut_vec, want); end
        end
        checks++;
        if (lat !== TOTAL) begin
            errors++;
            $display("[TB] FAIL mid_latency got %0d cycles, expected %0d", lat, TOTAL);
        end
    endtask

    task automatic test_over_restart();
        logic [13:0] want;
        int lat;
        int gap;
        gap = $urandom_range(1, 4);
        for (int i = 0; i < gap; i++) begin
            drive_edge(1'b0, 1'b0);
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("over_hold", dut_vec, want); end
        end
        drive_edge(1'b1, 1'b0);
        checks++;
        want = exp_vec();
        if (dut_vec !== want) begin errors++; show_fail("over_restart", dut_vec, want); end
        checks++;
        if ((state !== READY) || (game_over !== 1'b0) || (time_left !== 6'd5)) begin
            errors++;
            $display("[TB] FAIL over_restart_flags got st=%0d go=%0b tl=%0d, expected st=1 go=0 tl=5",
                     state, game_over, time_left);
        end
        lat = 0;
        while (!game_over && lat < 200) begin
            drive_edge(1'b0, 1'b0);
            lat++;
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("over_round2", dut_vec, want); end
        end
        checks++;
        if (lat !== TOTAL) begin
            errors++;
            $display("[TB] FAIL over_latency got %0d cycles, expected %0d", lat, TOTAL);
        end
    endtask

`ifdef WAM_PAUSE_EN
    task automatic test_pause();
        logic [13:0] want;
        int lat;
        drive_edge(1'b1, 1'b0);
        lat = 0;
        // run to time_left=4 with two cycles into the current second
        for (int i = 0; i < RT + TD + 2; i++) begin
            drive_edge(1'b0, 1'b0);
            lat++;
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("pause_pre", dut_vec, want); end
        end
        drive_edge(1'b0, 1'b1);
        lat++;
        checks++;
        want = exp_vec();
        if ((dut_vec !== want) || (state !== PAUSED)) begin errors++; show_fail("pause_enter", dut_vec, want); end
        for (int i = 0; i < 9; i++) begin
            drive_edge($urandom_range(0, 1) == 1, 1'b0);
            lat++;
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("pause_hold", dut_vec, want); end
        end
        drive_edge(1'b0, 1'b1);
        lat++;
        checks++;
        want = exp_vec();
        if ((dut_vec !== want) || (state !== PLAYING)) begin errors++; show_fail("pause_resume", dut_vec, want); end
        drive_edge(1'b0, 1'b0);
        lat++;
        checks++;
        if (sec_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_first_tick got sec_tick=%0b, expected 1", sec_tick);
        end
        while (!game_over && lat < 400) begin
            drive_edge(1'b0, 1'b0);
            lat++;
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("pause_tail", dut_vec, want); end
        end
        checks++;
        if (lat !== TOTAL + 10) begin
            errors++;
            $display("[TB] FAIL pause_latency got %0d cycles, expected %0d", lat, TOTAL + 10);
        end
        // random pause toggles across a whole round, including READY and OVER
        drive_edge(1'b1, 1'b0);
        lat = 0;
        while (!((m_e >= TOTAL) && !m_paused) && lat < 600) begin
            drive_edge(((m_e < TOTAL) || m_paused) && ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 4) == 0);
            lat++;
            checks++;
            want = exp_vec();
            if (dut_vec !== want) begin errors++; show_fail("pause_random", dut_vec, want); end
        end
        drive_edge(1'b0, 1'b1);
        checks++;
        want = exp_vec();
        if (dut_vec !== want) begin errors++; show_fail("pause_in_over", dut_vec, want); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        start_btn = 1'b0;
`ifdef WAM_PAUSE_EN
        pause_btn = 1'b0;
`endif
        model_reset();
        test_reset();
        test_round();
        test_start_ignored();
        test_mid_reset();
        test_over_restart();
`ifdef WAM_PAUSE_EN
        test_pause();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
